axi_lite_spill_join: RTL and testbench

AXI_LITE_SPILL_JOIN -- requirements
Module: axi_lite_spill_join

---
 rtl/axi_lite_pkg.sv | 70 +++++++
 rtl/axi_lite_spill_stage.sv | 86 ++++++++
 rtl/axi_lite_spill_join.sv | 111 +++++++++++
 tb/tb_axi_lite_spill_join.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_lite_pkg
//  Description : Shared AXI-Lite channel payloads, request/response bundles,
//                response encodings and the spill-stage state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package axi_lite_pkg;

    localparam int unsigned c_ADDR_WIDTH = 32;
    localparam int unsigned c_DATA_WIDTH = 32;
    localparam int unsigned c_STRB_WIDTH = c_DATA_WIDTH / 8;

    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [c_ADDR_WIDTH-1:0] addr;
        logic [2:0]              prot;
    } aw_chan_t;

    typedef struct packed {
        logic [c_DATA_WIDTH-1:0] data;
        logic [c_STRB_WIDTH-1:0] strb;
    } w_chan_t;

    typedef struct packed {
        logic [1:0] resp;
    } b_chan_t;

    typedef struct packed {
        logic [c_ADDR_WIDTH-1:0] addr;
        logic [2:0]              prot;
    } ar_chan_t;

    typedef struct packed {
        logic [c_DATA_WIDTH-1:0] data;
        logic [1:0]              resp;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic     aw_ready;
        logic     w_ready;
        b_chan_t  b;
        logic     b_valid;
        logic     ar_ready;
        r_chan_t  r;
        logic     r_valid;
    } resp_t;

    // Occupancy of a two-entry spill stage
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1,
        ST_FULL  = 2'd2
    } spill_state_e;

endpackage : axi_lite_pkg
`default_nettype wire

// File: rtl/axi_lite_spill_stage.sv
`default_nettype none
// ============================================================================
//  Module      : axi_lite_spill_stage
//  Description : One valid/ready channel, either a combinational wire-through
//                or a two-entry spill register with flop-driven valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_spill_stage
    import axi_lite_pkg::*;
#(
    parameter type payload_t = logic [31:0],
    parameter bit  Bypass    = 1'b0
) (
    input  logic     clk,
    input  logic     rst,
    // upstream side
    input  logic     i_valid,
    output logic     o_ready,
    input  payload_t i_data,
    // downstream side
    output logic     o_valid,
    input  logic     i_ready,
    output payload_t o_data,
    // stage holds at least one beat
    output logic     o_busy
);

    if (Bypass) begin : g_bypass
        // Clock and reset have no role when the channel is a plain wire
        logic w_unused_clk_rst;
        assign w_unused_clk_rst = clk ^ rst;

        assign o_valid = i_valid;
        assign o_ready = i_ready;
        assign o_data  = i_data;
        assign o_busy  = 1'b0;
    end else begin : g_spill
        spill_state_e r_state;
        payload_t     r_head;   // beat being presented downstream
        payload_t     r_tail;   // second beat parked while downstream stalls
        logic         w_push;
        logic         w_pop;

        // Handshakes are decoded purely from the state flop, so no
        // input-to-output combinational path exists on valid or ready.
        assign o_ready = (r_state != ST_FULL);
        assign o_valid = (r_state != ST_EMPTY);
        assign o_data  = r_head;
        assign o_busy  = (r_state != ST_EMPTY);
        assign w_push  = i_valid & o_ready;
        assign w_pop   = o_valid & i_ready;

        // Occupancy tracking; reset discards any held beats
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_state <= ST_EMPTY;
            end else begin
                case (r_state)
                    ST_EMPTY: if (w_push)            r_state <= ST_HALF;
                    ST_HALF: begin
                        if (w_push && !w_pop)        r_state <= ST_FULL;
                        else if (w_pop && !w_push)   r_state <= ST_EMPTY;
                    end
                    ST_FULL:  if (w_pop)             r_state <= ST_HALF;
                    default:                         r_state <= ST_EMPTY;
                endcase
            end
        end

        // Payload storage; head always holds the oldest beat, so a
        // simultaneous push/pop in HALF replaces the departing beat.
        always_ff @(posedge clk) begin
            case (r_state)
                ST_EMPTY: if (w_push) r_head <= i_data;
                ST_HALF: begin
                    if (w_push && w_pop) r_head <= i_data;
                    else if (w_push)     r_tail <= i_data;
                end
                ST_FULL:  if (w_pop)  r_head <= r_tail;
                default: ;
            endcase
        end
    end

endmodule : axi_lite_spill_stage
`default_nettype wire

// File: rtl/axi_lite_spill_join.sv
`default_nettype none
// ============================================================================
//  Module      : axi_lite_spill_join
//  Description : AXI-Lite register slice; each of the five channels is
//                independently a wire or a two-entry spill stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_spill_join #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter bit          CutAw     = 1'b1,
    parameter bit          CutW      = 1'b1,
    parameter bit          CutB      = 1'b1,
    parameter bit          CutAr     = 1'b1,
    parameter bit          CutR      = 1'b1,
    parameter type         req_t     = axi_lite_pkg::req_t,
    parameter type         resp_t    = axi_lite_pkg::resp_t
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  req_t  slv_req_i,
    output resp_t slv_resp_o,
    output req_t  mst_req_o,
    input  resp_t mst_resp_i,
    output logic  busy_o
);

    localparam int unsigned c_AW_BITS = $bits(slv_req_i.aw);
    localparam int unsigned c_W_BITS  = $bits(slv_req_i.w);
    localparam int unsigned c_B_BITS  = $bits(mst_resp_i.b);
    localparam int unsigned c_AR_BITS = $bits(slv_req_i.ar);
    localparam int unsigned c_R_BITS  = $bits(mst_resp_i.r);

    if (!(DataWidth == 32 || DataWidth == 64)) begin : g_bad_data_width
        $error("axi_lite_spill_join: DataWidth must be 32 or 64");
    end
    if ($bits(slv_req_i.w.data) != DataWidth ||
        $bits(slv_req_i.aw.addr) != AddrWidth) begin : g_bad_bundle_width
        $error("axi_lite_spill_join: req_t/resp_t widths disagree with parameters");
    end

    logic [c_AW_BITS-1:0] w_aw_data;
    logic [c_W_BITS-1:0]  w_w_data;
    logic [c_B_BITS-1:0]  w_b_data;
    logic [c_AR_BITS-1:0] w_ar_data;
    logic [c_R_BITS-1:0]  w_r_data;
    logic w_aw_valid, w_aw_ready, w_w_valid, w_w_ready, w_b_valid, w_b_ready;
    logic w_ar_valid, w_ar_ready, w_r_valid, w_r_ready;
    logic [4:0] w_busy;

    axi_lite_spill_stage #(.payload_t(logic [c_AW_BITS-1:0]), .Bypass(!CutAw)) u_aw (
        .clk(clk_i), .rst(rst_i),
        .i_valid(slv_req_i.aw_valid), .o_ready(w_aw_ready), .i_data(slv_req_i.aw),
        .o_valid(w_aw_valid), .i_ready(mst_resp_i.aw_ready), .o_data(w_aw_data),
        .o_busy(w_busy[0])
    );

    axi_lite_spill_stage #(.payload_t(logic [c_W_BITS-1:0]), .Bypass(!CutW)) u_w (
        .clk(clk_i), .rst(rst_i),
        .i_valid(slv_req_i.w_valid), .o_ready(w_w_ready), .i_data(slv_req_i.w),
        .o_valid(w_w_valid), .i_ready(mst_resp_i.w_ready), .o_data(w_w_data),
        .o_busy(w_busy[1])
    );

    axi_lite_spill_stage #(.payload_t(logic [c_B_BITS-1:0]), .Bypass(!CutB)) u_b (
        .clk(clk_i), .rst(rst_i),
        .i_valid(mst_resp_i.b_valid), .o_ready(w_b_ready), .i_data(mst_resp_i.b),
        .o_valid(w_b_valid), .i_ready(slv_req_i.b_ready), .o_data(w_b_data),
        .o_busy(w_busy[2])
    );

    axi_lite_spill_stage #(.payload_t(logic [c_AR_BITS-1:0]), .Bypass(!CutAr)) u_ar (
        .clk(clk_i), .rst(rst_i),
        .i_valid(slv_req_i.ar_valid), .o_ready(w_ar_ready), .i_data(slv_req_i.ar),
        .o_valid(w_ar_valid), .i_ready(mst_resp_i.ar_ready), .o_data(w_ar_data),
        .o_busy(w_busy[3])
    );

    axi_lite_spill_stage #(.payload_t(logic [c_R_BITS-1:0]), .Bypass(!CutR)) u_r (
        .clk(clk_i), .rst(rst_i),
        .i_valid(mst_resp_i.r_valid), .o_ready(w_r_ready), .i_data(mst_resp_i.r),
        .o_valid(w_r_valid), .i_ready(slv_req_i.r_ready), .o_data(w_r_data),
        .o_busy(w_busy[4])
    );

    // Reassemble the downstream request and upstream response bundles
    always_comb begin
        mst_req_o          = '0;
        mst_req_o.aw       = w_aw_data;
        mst_req_o.aw_valid = w_aw_valid;
        mst_req_o.w        = w_w_data;
        mst_req_o.w_valid  = w_w_valid;
        mst_req_o.b_ready  = w_b_ready;
        mst_req_o.ar       = w_ar_data;
        mst_req_o.ar_valid = w_ar_valid;
        mst_req_o.r_ready  = w_r_ready;

        slv_resp_o          = '0;
        slv_resp_o.aw_ready = w_aw_ready;
        slv_resp_o.w_ready  = w_w_ready;
        slv_resp_o.b        = w_b_data;
        slv_resp_o.b_valid  = w_b_valid;
        slv_resp_o.ar_ready = w_ar_ready;
        slv_resp_o.r        = w_r_data;
        slv_resp_o.r_valid  = w_r_valid;
    end

    assign busy_o = |w_busy;

endmodule : axi_lite_spill_join
`default_nettype wire

// File: tb/tb_axi_lite_spill_join.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_lite_spill_join
//  Description : Self-checking bench for axi_lite_spill_join (AR channel as
//                wire, all others as spill stages) against a queue model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_lite_spill_join;
    import axi_lite_pkg::*;

    logic  clk = 1'b0;
    logic  rst;
    req_t  slv_req;
    resp_t slv_resp;
    req_t  mst_req;
    resp_t mst_resp;
    logic  busy;

    int checks = 0;
    int errors = 0;

    // Beats accepted but not yet delivered, per cut channel: AW, W, B, R
    logic [127:0] q [4][$];

    axi_lite_spill_join #(
        .AddrWidth(32), .DataWidth(32),
        .CutAw(1'b1), .CutW(1'b1), .CutB(1'b1), .CutAr(1'b0), .CutR(1'b1)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .slv_req_i(slv_req), .slv_resp_o(slv_resp),
        .mst_req_o(mst_req), .mst_resp_i(mst_resp),
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // A two-entry buffer: valid out iff it holds a beat, ready in iff not
    // holding two, and the presented beat is always the oldest one held.
    task automatic chan(input int idx, input string tag,
                        input logic src_v, input logic src_r, input logic [127:0] src_p,
                        input logic dst_v, input logic dst_r, input logic [127:0] dst_p);
        int n;
        n = q[idx].size();
        check({tag, "_out_valid"}, 128'(dst_v), 128'(n > 0));
        check({tag, "_in_ready"},  128'(src_r), 128'(n < 2));
        if (dst_v && n > 0) check({tag, "_payload"}, dst_p, q[idx][0]);
        if (src_v && src_r) q[idx].push_back(src_p);
        if (dst_v && dst_r && n > 0) void'(q[idx].pop_front());
    endtask

    // Check the current cycle against the model, then advance one clock
    task automatic tick();
        #1;
        check("busy", 128'(busy),
              128'((q[0].size() + q[1].size() + q[2].size() + q[3].size()) != 0));
        chan(0, "aw", slv_req.aw_valid, slv_resp.aw_ready, 128'(slv_req.aw),
                      mst_req.aw_valid, mst_resp.aw_ready, 128'(mst_req.aw));
        chan(1, "w",  slv_req.w_valid, slv_resp.w_ready, 128'(slv_req.w),
                      mst_req.w_valid, mst_resp.w_ready, 128'(mst_req.w));
        chan(2, "b",  mst_resp.b_valid, mst_req.b_ready, 128'(mst_resp.b),
                      slv_resp.b_valid, slv_req.b_ready, 128'(slv_resp.b));
        chan(3, "r",  mst_resp.r_valid, mst_req.r_ready, 128'(mst_resp.r),
                      slv_resp.r_valid, slv_req.r_ready, 128'(slv_resp.r));
        check("ar_valid_wire", 128'(mst_req.ar_valid), 128'(slv_req.ar_valid));
        check("ar_ready_wire", 128'(slv_resp.ar_ready), 128'(mst_resp.ar_ready));
        check("ar_payload_wire", 128'(mst_req.ar), 128'(slv_req.ar));
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 4; i++) q[i].delete();
    endtask

    initial begin
        logic [31:0] wdat [3];
        wdat[0] = 32'hA5A5A5A5;
        wdat[1] = 32'h5A5A5A5A;
        wdat[2] = 32'h12345678;

        // ---- reset with an AW beat pending
        slv_req  = '0;
        mst_resp = '0;
        rst      = 1'b1;
        slv_req.aw_valid = 1'b1;
        slv_req.aw.addr  = 32'h100;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mst_aw_valid", 128'(mst_req.aw_valid), 128'(0));
        check("rst_slv_aw_ready", 128'(slv_resp.aw_ready), 128'(1));
        check("rst_busy", 128'(busy), 128'(0));
        rst = 1'b0;
        slv_req.aw_valid = 1'b0;
        #1;
        check("rel_mst_aw_valid", 128'(mst_req.aw_valid), 128'(0));
        check("rel_slv_aw_ready", 128'(slv_resp.aw_ready), 128'(1));
        check("rel_busy", 128'(busy), 128'(0));
        tick();
        check("rel1_mst_aw_valid", 128'(mst_req.aw_valid), 128'(0));
        check("rel1_slv_aw_ready", 128'(slv_resp.aw_ready), 128'(1));
        check("rel1_busy", 128'(busy), 128'(0));

        // ---- streaming 16 AW beats with the sink always ready
        mst_resp.aw_ready = 1'b1;
        for (int c = 0; c <= 17; c++) begin
            slv_req.aw_valid = (c < 16);
            slv_req.aw.addr  = 32'(c * 4);
            slv_req.aw.prot  = 3'($urandom);
            #1;
            check("stream_valid", 128'(mst_req.aw_valid), 128'(c >= 1 && c <= 16));
            if (c >= 1 && c <= 16)
                check("stream_addr", 128'(mst_req.aw.addr), 128'((c - 1) * 4));
            tick();
        end

        // ---- W backpressure: third beat must wait, head stays stable
        mst_resp.w_ready = 1'b0;
        slv_req.w_valid  = 1'b1;
        slv_req.w.strb   = 4'hF;
        for (int c = 0; c < 4; c++) begin
            slv_req.w.data = wdat[(c < 2) ? c : 2];
            #1;
            check("bp_slv_w_ready", 128'(slv_resp.w_ready), 128'(c < 2));
            if (c >= 1) check("bp_head_stable", 128'(mst_req.w.data), 128'(wdat[0]));
            tick();
        end
        mst_resp.w_ready = 1'b1;
        tick();
        #1;
        check("bp_after_release_ready", 128'(slv_resp.w_ready), 128'(1));
        check("bp_second", 128'(mst_req.w.data), 128'(wdat[1]));
        tick();
        slv_req.w_valid = 1'b0;
        #1;
        check("bp_third", 128'(mst_req.w.data), 128'(wdat[2]));
        tick();
        tick();

        // ---- R push and pop together while HALF, sink ready toggling
        mst_resp.r_valid  = 1'b1;
        mst_resp.r.data   = 32'h1;
        mst_resp.r.resp   = c_RESP_OKAY;
        slv_req.r_ready   = 1'b1;
        tick();
        mst_resp.r.data   = 32'h2;
        mst_resp.r.resp   = c_RESP_SLVERR;
        #1;
        check("r_first_data", 128'(slv_resp.r.data), 128'(1));
        tick();
        mst_resp.r_valid  = 1'b0;
        slv_req.r_ready   = 1'b0;
        #1;
        check("r_second_data", 128'(slv_resp.r.data), 128'(2));
        check("r_second_resp", 128'(slv_resp.r.resp), 128'(c_RESP_SLVERR));
        tick();
        slv_req.r_ready   = 1'b1;
        #1;
        check("r_second_held", 128'(slv_resp.r_valid), 128'(1));
        tick();
        tick();

        // ---- AR as a wire: same-cycle valid, payload and ready
        slv_req.ar_valid  = 1'b1;
        slv_req.ar.addr   = 32'hDEADBEE0;
        mst_resp.ar_ready = 1'b0;
        #1;
        check("ar_bypass_valid", 128'(mst_req.ar_valid), 128'(1));
        check("ar_bypass_addr", 128'(mst_req.ar.addr), 128'(32'hDEADBEE0));
        check("ar_bypass_ready0", 128'(slv_resp.ar_ready), 128'(0));
        mst_resp.ar_ready = 1'b1;
        #1;
        check("ar_bypass_ready1", 128'(slv_resp.ar_ready), 128'(1));
        tick();
        slv_req.ar_valid  = 1'b0;

        // ---- B stage filled, then reset pulsed mid-burst
        slv_req.b_ready  = 1'b0;
        mst_resp.b_valid = 1'b1;
        mst_resp.b.resp  = c_RESP_SLVERR;
        tick();
        mst_resp.b.resp  = c_RESP_OKAY;
        tick();
        mst_resp.b_valid = 1'b0;
        #1;
        check("b_full_ready", 128'(mst_req.b_ready), 128'(0));
        check("b_full_busy", 128'(busy), 128'(1));
        rst = 1'b1;
        #1;
        check("b_rst_valid", 128'(slv_resp.b_valid), 128'(0));
        check("b_rst_busy", 128'(busy), 128'(0));
        check("b_rst_ready", 128'(mst_req.b_ready), 128'(1));
        clear_model();
        @(posedge clk);
        #1;
        rst = 1'b0;
        mst_resp.b_valid = 1'b1;
        mst_resp.b.resp  = c_RESP_OKAY;
        slv_req.b_ready  = 1'b1;
        #1;
        check("b_post_rst_empty", 128'(slv_resp.b_valid), 128'(0));
        tick();
        mst_resp.b_valid = 1'b0;
        #1;
        check("b_post_rst_valid", 128'(slv_resp.b_valid), 128'(1));
        check("b_post_rst_resp", 128'(slv_resp.b.resp), 128'(c_RESP_OKAY));
        tick();

        // ---- randomized traffic on every channel
        for (int c = 0; c < 400; c++) begin
            slv_req.aw_valid  = 1'($urandom_range(0, 1));
            slv_req.aw.addr   = $urandom;
            slv_req.aw.prot   = 3'($urandom);
            slv_req.w_valid   = 1'($urandom_range(0, 1));
            slv_req.w.data    = $urandom;
            slv_req.w.strb    = 4'($urandom);
            slv_req.ar_valid  = 1'($urandom_range(0, 1));
            slv_req.ar.addr   = $urandom;
            slv_req.ar.prot   = 3'($urandom);
            slv_req.b_ready   = ($urandom_range(0, 3) != 0);
            slv_req.r_ready   = ($urandom_range(0, 3) != 0);
            mst_resp.b_valid  = 1'($urandom_range(0, 1));
            mst_resp.b.resp   = 2'($urandom);
            mst_resp.r_valid  = 1'($urandom_range(0, 1));
            mst_resp.r.data   = $urandom;
            mst_resp.r.resp   = 2'($urandom);
            mst_resp.aw_ready = ($urandom_range(0, 3) != 0);
            mst_resp.w_ready  = ($urandom_range(0, 3) != 0);
            mst_resp.ar_ready = 1'($urandom_range(0, 1));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_axi_lite_spill_join
`default_nettype wire
